// File: rtl/pio_ser_pkg.sv
// pio_ser_pkg: shared types and field positions for the PIO command serializer.
// Holds the FSM state enum, command-word field positions and the frame-length clamp.
package pio_ser_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LEAD,
        ST_HI,
        ST_LO,
        ST_TAIL
    } state_t;

    localparam int GO_BIT  = 31;
    localparam int LEN_MSB = 28;
    localparam int LEN_LSB = 24;
    localparam int PAY_W   = 24;
    localparam int MAX_LEN = 24;

    // len_m1 of 23..31 all yield a full 24-bit frame
    function automatic logic [4:0] clamp_len(input logic [4:0] len_m1);
        if (len_m1 >= 5'(MAX_LEN - 1))
            clamp_len = 5'(MAX_LEN);
        else
            clamp_len = len_m1 + 5'd1;
    endfunction

endpackage

// File: rtl/pio_ser_clkdiv.sv
// pio_ser_clkdiv: CLK_DIV-cycle tick generator for the serializer phases.
// Ports: clk, reset_n (async, active-low), i_restart (hold count at 0), o_tick (last cycle of a phase).
module pio_ser_clkdiv
    import pio_ser_pkg::*;
#(
    parameter int CLK_DIV = 4
) (
    input  logic clk,
    input  logic reset_n,
    input  logic i_restart,
    output logic o_tick
);

    localparam logic [7:0] LP_LAST = 8'(CLK_DIV - 1);

    logic [7:0] r_cnt;

    assign o_tick = (r_cnt == LP_LAST);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            r_cnt <= 8'd0;
        else if (i_restart || o_tick)
            r_cnt <= 8'd0;
        else
            r_cnt <= r_cnt + 8'd1;
    end

endmodule

// File: rtl/pio_cmd_serializer.sv
// pio_cmd_serializer: turns toggle-handshaked PIO command words into SPI-like frames.
// Ports: clk, reset_n, cmd_word[31:0] in; sclk, sdo, cs_n, busy, pending, done_tgl out.
// Build option: define PIO_SER_LSB_FIRST_EN to shift payload LSB first (default MSB first).
module pio_cmd_serializer
    import pio_ser_pkg::*;
#(
    parameter int CLK_DIV = 4
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [31:0] cmd_word,
    output logic        sclk,
    output logic        sdo,
    output logic        cs_n,
    output logic        busy,
    output logic        pending,
    output logic        done_tgl
);

    state_t      r_state;
    state_t      w_state_nxt;
    logic        r_go_seen;
    logic        r_sclk;
    logic        r_sdo;
    logic        r_cs_n;
    logic        r_busy;
    logic        r_pending;
    logic        r_done;
    logic [28:0] r_pbuf;
    logic [23:0] r_shift;
    logic [4:0]  r_bits;

    logic        w_sclk_nxt;
    logic        w_sdo_nxt;
    logic        w_cs_n_nxt;
    logic        w_busy_nxt;
    logic        w_done_nxt;
    logic [23:0] w_shift_nxt;
    logic [4:0]  w_bits_nxt;

    logic        w_accept;
    logic        w_start;
    logic        w_tick;
    logic        w_restart;
    logic [28:0] w_src;
    logic [4:0]  w_len;
    logic [23:0] w_load;
    logic [23:0] w_adv;
    logic        w_load_bit;
    logic        w_adv_bit;
    logic        w_unused;

    assign w_unused = ^cmd_word[30:29];

    assign w_accept  = (cmd_word[GO_BIT] != r_go_seen);
    assign w_start   = (r_state == ST_IDLE) && (w_accept || r_pending);
    // a fresh command in the same cycle beats the buffered one
    assign w_src     = w_accept ? cmd_word[LEN_MSB:0] : r_pbuf;
    assign w_len     = clamp_len(w_src[LEN_MSB:LEN_LSB]);
    assign w_restart = (r_state == ST_IDLE);

`ifdef PIO_SER_LSB_FIRST_EN
    assign w_load     = w_src[PAY_W-1:0];
    assign w_adv      = {1'b0, r_shift[23:1]};
    assign w_load_bit = w_load[0];
    assign w_adv_bit  = w_adv[0];
`else
    // left-align so payload[len-1] sits at bit 23
    assign w_load     = w_src[PAY_W-1:0] << (5'(MAX_LEN) - w_len);
    assign w_adv      = {r_shift[22:0], 1'b0};
    assign w_load_bit = w_load[23];
    assign w_adv_bit  = w_adv[23];
`endif

    pio_ser_clkdiv #(
        .CLK_DIV (CLK_DIV)
    ) u_clkdiv (
        .clk       (clk),
        .reset_n   (reset_n),
        .i_restart (w_restart),
        .o_tick    (w_tick)
    );

    always_comb begin
        w_state_nxt = r_state;
        w_sclk_nxt  = r_sclk;
        w_sdo_nxt   = r_sdo;
        w_cs_n_nxt  = r_cs_n;
        w_busy_nxt  = r_busy;
        w_done_nxt  = r_done;
        w_shift_nxt = r_shift;
        w_bits_nxt  = r_bits;
        unique case (r_state)
            ST_IDLE: begin
                if (w_start) begin
                    w_state_nxt = ST_LEAD;
                    w_cs_n_nxt  = 1'b0;
                    w_busy_nxt  = 1'b1;
                    w_sclk_nxt  = 1'b0;
                    w_shift_nxt = w_load;
                    w_sdo_nxt   = w_load_bit;
                    w_bits_nxt  = w_len;
                end
            end
            ST_LEAD, ST_LO: begin
                if (w_tick) begin
                    w_sclk_nxt  = 1'b1;
                    w_state_nxt = ST_HI;
                end
            end
            ST_HI: begin
                if (w_tick) begin
                    w_sclk_nxt = 1'b0;
                    if (r_bits == 5'd1) begin
                        w_state_nxt = ST_TAIL;
                    end else begin
                        w_shift_nxt = w_adv;
                        w_sdo_nxt   = w_adv_bit;
                        w_bits_nxt  = r_bits - 5'd1;
                        w_state_nxt = ST_LO;
                    end
                end
            end
            ST_TAIL: begin
                if (w_tick) begin
                    w_cs_n_nxt  = 1'b1;
                    w_busy_nxt  = 1'b0;
                    w_done_nxt  = ~r_done;
                    w_sdo_nxt   = 1'b0;
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state   <= ST_IDLE;
            r_go_seen <= 1'b0;
            r_sclk    <= 1'b0;
            r_sdo     <= 1'b0;
            r_cs_n    <= 1'b1;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_pending <= 1'b0;
            r_pbuf    <= '0;
            r_shift   <= '0;
            r_bits    <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_go_seen <= cmd_word[GO_BIT];
            r_sclk    <= w_sclk_nxt;
            r_sdo     <= w_sdo_nxt;
            r_cs_n    <= w_cs_n_nxt;
            r_busy    <= w_busy_nxt;
            r_done    <= w_done_nxt;
            r_shift   <= w_shift_nxt;
            r_bits    <= w_bits_nxt;
            if (w_accept && (r_state != ST_IDLE)) begin
                r_pending <= 1'b1;
                r_pbuf    <= cmd_word[LEN_MSB:0];
            end else if (w_start) begin
                r_pending <= 1'b0;
            end
        end
    end

    assign sclk     = r_sclk;
    assign sdo      = r_sdo;
    assign cs_n     = r_cs_n;
    assign busy     = r_busy;
    assign pending  = r_pending;
    assign done_tgl = r_done;

endmodule

// File: tb/tb_pio_cmd_serializer.sv
// tb_pio_cmd_serializer: directed + randomized checks of pio_cmd_serializer.
// Frame model: bit list and timing derived from word fields with plain arithmetic.
module tb_pio_cmd_serializer;

    localparam int DIV = 2;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [31:0] cmd_word;
    logic [31:0] cmd1;
    logic        sclk, sdo, cs_n, busy, pending, done_tgl;
    logic        sclk1, sdo1, cs_n1, busy1, pending1, done_tgl1;

    always #5 clk = ~clk;

    pio_cmd_serializer #(.CLK_DIV(DIV)) u_dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .cmd_word (cmd_word),
        .sclk     (sclk),
        .sdo      (sdo),
        .cs_n     (cs_n),
        .busy     (busy),
        .pending  (pending),
        .done_tgl (done_tgl)
    );

    pio_cmd_serializer #(.CLK_DIV(1)) u_dut1 (
        .clk      (clk),
        .reset_n  (reset_n),
        .cmd_word (cmd1),
        .sclk     (sclk1),
        .sdo      (sdo1),
        .cs_n     (cs_n1),
        .busy     (busy1),
        .pending  (pending1),
        .done_tgl (done_tgl1)
    );

    int compared = 0;
    int mismatched = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // frame log of main DUT, built by observing pins
    int          rec_low[$];
    int          rec_n[$];
    int          rec_hi[$];
    int          rec_gap[$];
    logic [23:0] rec_bits[$];
    int          m_low, m_n, m_hi_run, m_hi_max, m_high_run, m_gap;
    logic [23:0] m_bits;
    bit          m_in;
    logic        m_prev;

    initial begin
        m_in = 0; m_high_run = 0; m_prev = 1'b0;
        m_low = 0; m_n = 0; m_hi_run = 0; m_hi_max = 0; m_gap = 0; m_bits = '0;
        forever begin
            @(negedge clk);
            if (reset_n !== 1'b1) begin
                m_in = 0; m_high_run = 0; m_prev = 1'b0;
            end else if (cs_n === 1'b0) begin
                if (!m_in) begin
                    m_in = 1; m_low = 0; m_n = 0; m_bits = '0;
                    m_hi_run = 0; m_hi_max = 0; m_gap = m_high_run;
                end
                m_low++;
                if (sclk === 1'b1 && m_prev !== 1'b1) begin
                    m_bits = {m_bits[22:0], sdo};
                    m_n++;
                end
                if (sclk === 1'b1) begin
                    m_hi_run++;
                    if (m_hi_run > m_hi_max) m_hi_max = m_hi_run;
                end else begin
                    m_hi_run = 0;
                end
                m_high_run = 0;
                m_prev = sclk;
            end else begin
                if (m_in) begin
                    rec_low.push_back(m_low);
                    rec_n.push_back(m_n);
                    rec_hi.push_back(m_hi_max);
                    rec_gap.push_back(m_gap);
                    rec_bits.push_back(m_bits);
                end
                m_in = 0;
                m_high_run++;
                m_prev = sclk;
            end
        end
    end

    function automatic int f_len(input logic [31:0] w);
        int l;
        l = int'(w[28:24]) + 1;
        return (l > 24) ? 24 : l;
    endfunction

    // transmitted bits, first-sent bit at position len-1
    function automatic logic [23:0] f_bits(input logic [31:0] w);
        int          l;
        logic [23:0] r;
        l = f_len(w);
        r = '0;
        for (int i = 0; i < l; i++) begin
`ifdef PIO_SER_LSB_FIRST_EN
            r[l-1-i] = w[i];
`else
            r[l-1-i] = w[l-1-i];
`endif
        end
        return r;
    endfunction

    logic go;
    int   exp_done;

    task automatic send(input logic [4:0] lm1, input logic [23:0] pay, output logic [31:0] w);
        logic [1:0] junk;
        @(negedge clk);
        junk = 2'($urandom_range(3));
        go = ~go;
        w = {go, junk, lm1, pay};
        cmd_word = w;
    endtask

    task automatic wait_rec(input int k, input string tag);
        int t;
        t = 0;
        while (rec_low.size() < k && t < 3000) begin
            @(negedge clk);
            #1;
            t++;
        end
        compared++;
        assert (rec_low.size() >= k) else begin
            mismatched++;
            $error("FAIL %s timeout frames=%0d required=%0d", tag, rec_low.size(), k);
        end
    endtask

    task automatic check_frame(input int idx, input logic [31:0] w, input string tag);
        int l;
        l = f_len(w);
        chk({tag, "_low"}, 64'(rec_low[idx]), 64'((2 * l + 1) * DIV));
        chk({tag, "_nbits"}, 64'(rec_n[idx]), 64'(l));
        chk({tag, "_bits"}, 64'(rec_bits[idx]), 64'(f_bits(w)));
        chk({tag, "_sclkhi"}, 64'(rec_hi[idx]), 64'(DIV));
    endtask

    logic [31:0] w, wa, wb, wc;
    int          n;
    int          t;
    int          low1, hi1;
    logic        bit1;

    initial begin
        reset_n  = 1'b0;
        cmd_word = '0;
        cmd1     = '0;
        go       = 1'b0;
        exp_done = 0;
        repeat (3) @(negedge clk);
        #1;
        chk("rst_cs_n", 64'(cs_n), 64'(1));
        chk("rst_sclk", 64'(sclk), 64'(0));
        chk("rst_sdo", 64'(sdo), 64'(0));
        chk("rst_busy", 64'(busy), 64'(0));
        chk("rst_pending", 64'(pending), 64'(0));
        chk("rst_done", 64'(done_tgl), 64'(0));
        @(negedge clk);
        reset_n = 1'b1;
        repeat (10) @(negedge clk);
        #1;
        chk("idle_cs_n", 64'(cs_n), 64'(1));
        chk("idle_frames", 64'(rec_low.size()), 64'(0));

        // first frame from reset
        @(negedge clk);
        go = 1'b1;
        w = 32'h8700_00A5;
        cmd_word = w;
        wait_rec(1, "r030_wait");
        exp_done ^= 1;
        check_frame(0, w, "r030");
        chk("r030_low34", 64'(rec_low[0]), 64'(34));
        chk("r030_a5", 64'(rec_bits[0]), 64'(24'hA5));
        chk("r030_done", 64'(done_tgl), 64'(exp_done));
        n = 1;

        // len_m1 clamp
        send(5'd31, 24'hFFF00F, w);
        wait_rec(n + 1, "r031_wait");
        exp_done ^= 1;
        check_frame(n, w, "r031");
        chk("r031_rises", 64'(rec_n[n]), 64'(24));
        chk("r031_low", 64'(rec_low[n]), 64'(49 * DIV));
        chk("r031_done", 64'(done_tgl), 64'(exp_done));
        n++;

        // randomized frames
        for (int k = 0; k < 8; k++) begin
            send(5'($urandom_range(31)), 24'($urandom), w);
            wait_rec(n + 1, "rnd_wait");
            exp_done ^= 1;
            check_frame(n, w, "rnd");
            chk("rnd_done", 64'(done_tgl), 64'(exp_done));
            chk("rnd_busy", 64'(busy), 64'(0));
            n++;
        end

        // pending buffer, last command wins
        send(5'd7, 24'($urandom), wa);
        repeat (6) @(negedge clk);
        send(5'd7, 24'h000011, wb);
        repeat (3) @(negedge clk);
        #1;
        chk("r032_pend1", 64'(pending), 64'(1));
        chk("r032_busy", 64'(busy), 64'(1));
        send(5'd7, 24'h000022, wc);
        repeat (2) @(negedge clk);
        #1;
        chk("r032_pend2", 64'(pending), 64'(1));
        wait_rec(n + 1, "r032_waitA");
        exp_done ^= 1;
        check_frame(n, wa, "r032A");
        chk("r032_pend_gap", 64'(pending), 64'(1));
        @(negedge clk);
        #1;
        chk("r032_restart", 64'(cs_n), 64'(0));
        chk("r032_pend_clr", 64'(pending), 64'(0));
        n++;
        wait_rec(n + 1, "r032_waitC");
        exp_done ^= 1;
        check_frame(n, wc, "r032C");
        chk("r032_gap", 64'(rec_gap[n]), 64'(1));
        chk("r032_done", 64'(done_tgl), 64'(exp_done));
        n++;
        repeat (60) @(negedge clk);
        #1;
        chk("r032_nframes", 64'(rec_low.size()), 64'(n));

        // reset mid-frame during bit 3
        send(5'd7, 24'($urandom), w);
        t = 0;
        while (!(m_in && m_n == 3) && t < 200) begin
            @(negedge clk);
            #1;
            t++;
        end
        chk("r033_reach", 64'(m_n), 64'(3));
        #2;
        reset_n = 1'b0;
        #1;
        chk("r033_cs_n", 64'(cs_n), 64'(1));
        chk("r033_sclk", 64'(sclk), 64'(0));
        chk("r033_busy", 64'(busy), 64'(0));
        chk("r033_done", 64'(done_tgl), 64'(0));
        cmd_word = '0;
        go = 1'b0;
        exp_done = 0;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        repeat (12) @(negedge clk);
        #1;
        chk("r033_idle", 64'(cs_n), 64'(1));
        chk("r033_nframes", 64'(rec_low.size()), 64'(n));

        // recovery after reset
        send(5'($urandom_range(31)), 24'($urandom), w);
        wait_rec(n + 1, "post_wait");
        exp_done ^= 1;
        check_frame(n, w, "post");
        chk("post_done", 64'(done_tgl), 64'(exp_done));
        n++;

        // CLK_DIV=1, single bit
        @(negedge clk);
        cmd1 = 32'h8000_0001;
        low1 = 0;
        hi1 = 0;
        bit1 = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            #1;
            if (cs_n1 === 1'b0) low1++;
            if (sclk1 === 1'b1) begin
                hi1++;
                bit1 = sdo1;
            end
        end
        chk("r035_low", 64'(low1), 64'(3));
        chk("r035_sclkhi", 64'(hi1), 64'(1));
        chk("r035_bit", 64'(bit1), 64'(1));
        chk("r035_done", 64'(done_tgl1), 64'(1));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/pio_cmd_serializer.md
PIO_CMD_SERIALIZER -- requirements
Module: pio_cmd_serializer

Interface
REQ-001 Parameter CLK_DIV, default 4: sclk half-period in clk cycles; legal range 1..255.
REQ-002 clk  input  1  system clock; all logic on its rising edge.
REQ-003 reset_n  input  1  reset, asynchronous, active-low.
REQ-004 cmd_word  input  32  command word driven directly by the upstream 32-bit output PIO register; same clock domain, no synchroniser.
REQ-005 sclk  output  1  serial clock; idles low.
REQ-006 sdo  output  1  serial data out.
REQ-007 cs_n  output  1  frame select, active-low.
REQ-008 busy  output  1  high while a frame is in progress.
REQ-009 pending  output  1  high while one accepted command waits behind the active frame.
REQ-010 done_tgl  output  1  toggles once per completed frame; intended for an upstream input PIO.

Function
REQ-011 Command word fields: [31] go toggle; [28:24] len_m1; [23:0] payload; bits [30:29] ignored.
REQ-012 The block shall keep a registered go_seen bit; a command is accepted on any cycle where cmd_word[31] != go_seen, and go_seen updates to cmd_word[31] on that cycle.
REQ-013 Frame length = min(len_m1+1, 24) bits; len_m1 values 24..31 clamp to 24.
REQ-014 Bit order: MSB first, payload[len-1] down to payload[0].
REQ-015 FSM states: IDLE, LEAD, HI, LO, TAIL.
REQ-016 IDLE + accept at edge T: at T+1 cs_n=0, busy=1, sdo=first bit, sclk=0; state LEAD.
REQ-017 LEAD and LO last CLK_DIV cycles each, then sclk rises -> HI.
REQ-018 HI lasts CLK_DIV cycles, then sclk falls. On that edge: not last bit -> next bit on sdo, -> LO; last bit -> sdo holds, -> TAIL.
REQ-019 TAIL lasts CLK_DIV cycles, then in one cycle: cs_n=1, busy=0, done_tgl inverts, sdo=0; -> IDLE or next frame (REQ-021).
REQ-020 cs_n low duration shall be exactly (2*len+1)*CLK_DIV cycles.
REQ-021 Accept while busy: latch the word into a one-entry pending buffer, pending=1; at frame end start the pending frame on the next cycle (cs_n high for exactly 1 cycle); pending clears when that frame starts.
REQ-022 Accept while pending=1: overwrite the buffer (last command wins); no error flag.
REQ-023 Payload and length are captured at accept; later cmd_word changes do not affect an active frame.

Reset
REQ-024 reset_n low shall asynchronously force sclk=0, sdo=0, cs_n=1, busy=0, pending=0, done_tgl=0, go_seen=0, state IDLE, divider count 0.
REQ-025 Reset mid-frame shall abort immediately; no partial done_tgl.
REQ-026 After reset, cmd_word reset value 0 shall not start a frame.

Configuration
REQ-027 Macro PIO_SER_LSB_FIRST_EN: defined -> bit order payload[0] up to payload[len-1]; undefined -> MSB first per REQ-014. Timing identical either way.

Structure
REQ-028 Package pio_ser_pkg holds the state enum, field positions (GO_BIT=31, LEN_MSB=28, LEN_LSB=24, PAY_W=24) and MAX_LEN=24.
REQ-029 One sub-module pio_ser_clkdiv: CLK_DIV-cycle tick counter, restart input, tick output; reset_n async to count 0.

Verification
REQ-030 CLK_DIV=2, cmd_word=0x8700_00A5 from reset -> cs_n low 34 cycles; sdo sampled on sclk rise = 1,0,1,0,0,1,0,1; done_tgl 0->1.
REQ-031 len_m1=31, payload 0xFFF00F -> exactly 24 sclk rising edges, cs_n low 49*CLK_DIV cycles.
REQ-032 Toggle bit 31 twice during a frame with payloads 0x11 then 0x22 (len 8) -> only 0x22 sent second; pending high until second frame starts; cs_n high exactly 1 cycle between frames; done_tgl toggles twice total.
REQ-033 Assert reset_n low mid-bit 3 -> same cycle cs_n=1, sclk=0, busy=0; done_tgl unchanged at 0; idle after release with cmd_word[31]=0.
REQ-034 With PIO_SER_LSB_FIRST_EN, 0x8300_0001 (len 4) -> sdo on sclk rise = 1,0,0,0.
REQ-035 CLK_DIV=1, len 1 -> cs_n low exactly 3 cycles; sclk high exactly 1 cycle.
